// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/ready byte holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with parity_err reporting.
module uart_rx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rx_s;
    logic          byte_done;
    logic          cnt_zero;

`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    assign rx_s     = sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        sync_d    = {sync_q[0], rx};
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        byte_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_M1;
                    state_d = START;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = FULL_M1;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_d   = rx_s;
                    cnt_d   = FULL_M1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    // a low stop bit may be a break; wait for the line to idle
                    ferr_d  = 1'b1;
                    state_d = WAIT_IDLE;
                end else begin
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (^{shift_q, par_q}) begin
                        perr_d = 1'b1;
                    end else begin
                        byte_done = 1'b1;
                    end
`else
                    byte_done = 1'b1;
`endif
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (byte_done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: vector table, corner sequences and random frames vs a byte-level model.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int CPB    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    uart_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    logic [7:0] got_arr [0:1023];
    int got_n  = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    int n_perr = 0;
    int n_vcyc = 0;
    int n_both = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) begin
                got_arr[got_n % 1024] = data;
                got_n++;
            end
            if (valid && ready) n_vcyc++;
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (parity_err) n_perr++;
            if (frame_err && overrun) n_both++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_ok,
                              input int par_ok);
        logic pbit;
        pbit = (par_ok != 0) ? ^d : ~^d;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(pbit);
`endif
        send_bit(stop_ok != 0);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        int         stop_ok;
        int         par_ok;
        int         exp_n;
        logic [7:0] exp_d;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] exp_q[$];

    initial begin
        int g0, f0, p0, v0, o0;
        int exp_ferr, exp_perr;

        vecs.push_back('{8'hA5, 1, 1, 1, 8'hA5, 0, 0});
        vecs.push_back('{8'h3C, 0, 1, 0, 8'h00, 1, 0});
        vecs.push_back('{8'h55, 1, 1, 1, 8'h55, 0, 0});
        vecs.push_back('{8'hC3, 1, 1, 1, 8'hC3, 0, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1, 0, 0, 8'h00, 0, 1});
        vecs.push_back('{8'h07, 0, 0, 0, 8'h00, 1, 0});
`endif

        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (5) tick();
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_parity_err", int'(parity_err), 0);
        rst_n = 1'b1;
        repeat (20) tick();

        foreach (vecs[i]) begin
            g0 = got_n; f0 = n_ferr; p0 = n_perr; v0 = n_vcyc;
            send_frame(vecs[i].d, vecs[i].stop_ok, vecs[i].par_ok);
            repeat (3 * CPB) tick();
            chk($sformatf("vec%0d_nbytes", i), got_n - g0, vecs[i].exp_n);
            if (vecs[i].exp_n > 0)
                chk($sformatf("vec%0d_data", i), int'(got_arr[g0]),
                    int'(vecs[i].exp_d));
            chk($sformatf("vec%0d_valid_cycles", i), n_vcyc - v0, vecs[i].exp_n);
            chk($sformatf("vec%0d_frame_err", i), n_ferr - f0, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_parity_err", i), n_perr - p0, vecs[i].exp_perr);
        end

        // glitch shorter than half a bit
        g0 = got_n; f0 = n_ferr;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (8) tick();
        chk("glitch_nbytes", got_n - g0, 0);
        chk("glitch_frame_err", n_ferr - f0, 0);
        send_frame(8'h5A, 1, 1);
        repeat (2 * CPB) tick();
        chk("post_glitch_nbytes", got_n - g0, 1);
        chk("post_glitch_data", int'(got_arr[g0]), 8'h5A);

        // back-to-back frames, no idle gap
        g0 = got_n; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h00, 1, 1);
        send_frame(8'hFF, 1, 1);
        send_frame(8'h81, 1, 1);
        repeat (3 * CPB) tick();
        chk("b2b_nbytes", got_n - g0, 3);
        chk("b2b_data0", int'(got_arr[g0]), 8'h00);
        chk("b2b_data1", int'(got_arr[g0 + 1]), 8'hFF);
        chk("b2b_data2", int'(got_arr[g0 + 2]), 8'h81);
        chk("b2b_errors", (n_ferr - f0) + (n_ovr - o0), 0);

        // overrun with the holding register full
        ready = 1'b0;
        g0 = got_n; o0 = n_ovr;
        send_frame(8'h11, 1, 1);
        send_frame(8'h22, 1, 1);
        repeat (3 * CPB) tick();
        chk("ovr_valid_held", int'(valid), 1);
        chk("ovr_data_held", int'(data), 8'h11);
        chk("ovr_pulses", n_ovr - o0, 1);
        ready = 1'b1;
        tick();
        chk("ovr_accept_nbytes", got_n - g0, 1);
        chk("ovr_accept_data", int'(got_arr[g0]), 8'h11);
        chk("ovr_valid_cleared", int'(valid), 0);
        repeat (5) tick();
        chk("ovr_no_second", got_n - g0, 1);

        // reset during bit 4 of 0x7E
        g0 = got_n; f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h7E >> i));
        rx = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) tick();
        chk("midrst_valid", int'(valid), 0);
        rst_n = 1'b1;
        repeat (20) tick();
        send_frame(8'h42, 1, 1);
        repeat (3 * CPB) tick();
        chk("midrst_nbytes", got_n - g0, 1);
        chk("midrst_data", int'(got_arr[g0]), 8'h42);
        chk("midrst_frame_err", n_ferr - f0, 0);

        // random frames against a byte-level model
        exp_q.delete();
        exp_ferr = 0;
        exp_perr = 0;
        g0 = got_n; f0 = n_ferr; p0 = n_perr; v0 = n_vcyc;
        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            int bad_stop, bad_par, gap;
            d = 8'($urandom);
            bad_stop = ($urandom_range(0, 5) == 0) ? 1 : 0;
`ifdef UART_RX_PARITY_EN
            bad_par = ($urandom_range(0, 5) == 0) ? 1 : 0;
`else
            bad_par = 0;
`endif
            gap = (bad_stop != 0) ? 15 : $urandom_range(0, 12);
            send_frame(d, 1 - bad_stop, 1 - bad_par);
            repeat (gap) tick();
            if (bad_stop != 0) exp_ferr++;
            else if (bad_par != 0) exp_perr++;
            else exp_q.push_back(d);
        end
        repeat (3 * CPB) tick();
        chk("rand_nbytes", got_n - g0, exp_q.size());
        chk("rand_valid_cycles", n_vcyc - v0, exp_q.size());
        chk("rand_frame_err", n_ferr - f0, exp_ferr);
        chk("rand_parity_err", n_perr - p0, exp_perr);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_n - g0)
                chk($sformatf("rand_data%0d", k), int'(got_arr[g0 + k]),
                    int'(exp_q[k]));
        end

        chk("ferr_ovr_exclusive", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
